// File: rtl/iopmp_tl_err_resp.sv
// rtl/iopmp_tl_err_resp.sv - per-master TL-UL error responder for denied IOPMP requests
//
// Purpose:
//   Absorbs A-channel requests that the IOPMP checker denied and answers each
//   one with a TL-UL D-channel response carrying d_error=1. Every master owns
//   an independent DEPTH-entry FIFO of pending {opcode, source, size} tuples;
//   responses leave in arrival order. Masters share no state.
//
// Ports (vectors are packed per master, master m at slice [W*m +: W]):
//   clk_i, rst_i        clock, asynchronous active-high reset
//   blk_valid_i/ready_o denied-request handshake, per master
//   blk_opcode_i        a_opcode (3 bits per master)
//   blk_source_i        a_source (AIW bits per master)
//   blk_size_i          a_size   (SZW bits per master)
//   d_valid_o/d_ready_i D-channel handshake, per master
//   d_opcode_o          AccessAckData(1) for Get, AccessAck(0) otherwise
//   d_source_o/d_size_o echoed source and size
//   d_error_o           always 1 while d_valid_o is 1
//   d_data_o            always 0
//   busy_o              control state per master (0=NO_OP, 1=RESP)
//
// Optional feature (macro IOPMP_ERR_CNT_EN):
//   cnt_clr_i           per-master synchronous clear of the violation counter
//   cnt_o               16-bit saturating count of accepted denied requests

module iopmp_tl_err_resp #(
  parameter int NUM_MASTERS = 3,
  parameter int DEPTH       = 2,
  parameter int AIW         = 8,
  parameter int SZW         = 2,
  parameter int DW          = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_MASTERS-1:0]     blk_valid_i,
  output logic [NUM_MASTERS-1:0]     blk_ready_o,
  input  logic [3*NUM_MASTERS-1:0]   blk_opcode_i,
  input  logic [AIW*NUM_MASTERS-1:0] blk_source_i,
  input  logic [SZW*NUM_MASTERS-1:0] blk_size_i,
  output logic [NUM_MASTERS-1:0]     d_valid_o,
  input  logic [NUM_MASTERS-1:0]     d_ready_i,
  output logic [3*NUM_MASTERS-1:0]   d_opcode_o,
  output logic [AIW*NUM_MASTERS-1:0] d_source_o,
  output logic [SZW*NUM_MASTERS-1:0] d_size_o,
  output logic [NUM_MASTERS-1:0]     d_error_o,
  output logic [DW*NUM_MASTERS-1:0]  d_data_o,
  output logic [NUM_MASTERS-1:0]     busy_o
`ifdef IOPMP_ERR_CNT_EN
  ,
  input  logic [NUM_MASTERS-1:0]     cnt_clr_i,
  output logic [16*NUM_MASTERS-1:0]  cnt_o
`endif
);

  // A pointer needs at least one bit even when DEPTH is 1.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 3 + AIW + SZW;

  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK       = 3'd0;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;

  localparam logic [0:0] ST_NO_OP = 1'b0;
  localparam logic [0:0] ST_RESP  = 1'b1;

  // Wraps at DEPTH explicitly so non-trivial depths of 1 behave correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Only Get returns data; Put* and anything unrecognised get a plain ack.
  function automatic logic [2:0] map_opcode(input logic [2:0] op);
    return (op == OP_GET) ? OP_ACK_DATA : OP_ACK;
  endfunction

  assign d_data_o = '0;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_ch
    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [0:0]     state;
    logic [0:0]     state_next;
    logic           push;
    logic           pop;
    logic           valid;
    logic [EW-1:0]  head;
    logic [2:0]     head_op;
    logic [AIW-1:0] head_src;
    logic [SZW-1:0] head_size;

    // Ready comes only from the registered count, so a full queue never
    // accepts in the same cycle it pops.
    assign blk_ready_o[m] = (count != CW'(DEPTH));
    assign valid          = (count != '0);
    assign push           = blk_valid_i[m] & blk_ready_o[m];
    assign pop            = valid & d_ready_i[m];

    // Payload storage needs no reset: it is only visible while count > 0.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wptr] <= {blk_opcode_i[3*m +: 3],
                      blk_source_i[AIW*m +: AIW],
                      blk_size_i[SZW*m +: SZW]};
      end
    end

    always_comb begin
      state_next = state;
      case (state)
        ST_NO_OP: if (push) state_next = ST_RESP;
        ST_RESP:  if (pop && !push && (count == CW'(1))) state_next = ST_NO_OP;
        default:  state_next = ST_NO_OP;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        state <= ST_NO_OP;
      end else begin
        if (push) wptr <= ptr_inc(wptr);
        if (pop)  rptr <= ptr_inc(rptr);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        state <= state_next;
      end
    end

    assign head      = mem[rptr];
    assign head_op   = head[EW-1 -: 3];
    assign head_src  = head[SZW +: AIW];
    assign head_size = head[SZW-1:0];

    // Outputs are forced to zero when idle so reset leaves them clean even
    // though the storage array itself is not cleared.
    assign d_valid_o[m]              = valid;
    assign d_error_o[m]              = valid;
    assign d_opcode_o[3*m +: 3]      = valid ? map_opcode(head_op) : 3'd0;
    assign d_source_o[AIW*m +: AIW]  = valid ? head_src : '0;
    assign d_size_o[SZW*m +: SZW]    = valid ? head_size : '0;
    assign busy_o[m]                 = state[0];

`ifdef IOPMP_ERR_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt <= '0;
      end else if (cnt_clr_i[m]) begin
        cnt <= '0;
      end else if (push && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end

    assign cnt_o[16*m +: 16] = cnt;
`endif
  end

endmodule

// File: tb/tb_iopmp_tl_err_resp.sv
// tb/tb_iopmp_tl_err_resp.sv - self-checking bench for iopmp_tl_err_resp
module tb_iopmp_tl_err_resp;
  localparam int NM    = 3;
  localparam int DEPTH = 2;
  localparam int AIW   = 8;
  localparam int SZW   = 2;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [NM-1:0]       blk_valid;
  logic [NM-1:0]       blk_ready;
  logic [3*NM-1:0]     blk_opcode;
  logic [AIW*NM-1:0]   blk_source;
  logic [SZW*NM-1:0]   blk_size;
  logic [NM-1:0]       d_valid;
  logic [NM-1:0]       d_ready;
  logic [3*NM-1:0]     d_opcode;
  logic [AIW*NM-1:0]   d_source;
  logic [SZW*NM-1:0]   d_size;
  logic [NM-1:0]       d_error;
  logic [DW*NM-1:0]    d_data;
  logic [NM-1:0]       busy;
`ifdef IOPMP_ERR_CNT_EN
  logic [NM-1:0]       cnt_clr;
  logic [16*NM-1:0]    cnt;
`endif

  int errors = 0;
  int checks = 0;

  iopmp_tl_err_resp #(.NUM_MASTERS(NM), .DEPTH(DEPTH), .AIW(AIW), .SZW(SZW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
    .blk_opcode_i(blk_opcode), .blk_source_i(blk_source), .blk_size_i(blk_size),
    .d_valid_o(d_valid), .d_ready_i(d_ready),
    .d_opcode_o(d_opcode), .d_source_o(d_source), .d_size_o(d_size),
    .d_error_o(d_error), .d_data_o(d_data), .busy_o(busy)
`ifdef IOPMP_ERR_CNT_EN
    , .cnt_clr_i(cnt_clr), .cnt_o(cnt)
`endif
  );

  always #5 clk = ~clk;

  // advance one clock; stimulus and sampling happen on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    blk_valid = '0; blk_opcode = '0; blk_source = '0; blk_size = '0; d_ready = '0;
`ifdef IOPMP_ERR_CNT_EN
    cnt_clr = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input int m, input logic [2:0] op, input logic [7:0] src, input logic [1:0] sz);
    blk_valid[m] = 1'b1;
    blk_opcode[3*m +: 3] = op;
    blk_source[AIW*m +: AIW] = src;
    blk_size[SZW*m +: SZW] = sz;
  endtask

  task automatic test_reset();
    checks++; if (blk_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got=%b exp=111", blk_ready); end
    checks++; if (d_valid !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b exp=000", d_valid); end
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got=%b exp=000", busy); end
    checks++; if ({d_opcode, d_source, d_size, d_error, d_data} !== '0) begin errors++; $display("FAIL reset_data got nonzero outputs"); end
  endtask

  task automatic test_single_get();
    drive(0, 3'd4, 8'h2A, 2'd2);
    tick();
    blk_valid[0] = 1'b0;
    checks++; if (d_valid[0] !== 1'b1) begin errors++; $display("FAIL get_valid got=%b exp=1", d_valid[0]); end
    checks++; if (d_opcode[2:0] !== 3'd1) begin errors++; $display("FAIL get_opcode got=%0d exp=1", d_opcode[2:0]); end
    checks++; if (d_source[7:0] !== 8'h2A) begin errors++; $display("FAIL get_source got=%h exp=2a", d_source[7:0]); end
    checks++; if (d_size[1:0] !== 2'd2) begin errors++; $display("FAIL get_size got=%0d exp=2", d_size[1:0]); end
    checks++; if (d_error[0] !== 1'b1 || d_data[31:0] !== 32'h0) begin errors++; $display("FAIL get_err_data got err=%b data=%h exp err=1 data=0", d_error[0], d_data[31:0]); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL get_busy got=%b exp=1", busy[0]); end
    d_ready[0] = 1'b1;
    tick();
    d_ready[0] = 1'b0;
    checks++; if (d_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL get_pop got valid=%b busy=%b exp 0 0", d_valid[0], busy[0]); end
  endtask

  task automatic test_stall();
    drive(1, 3'd0, 8'h11, 2'd1);
    tick();
    blk_valid[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (d_valid[1] !== 1'b1 || d_opcode[5:3] !== 3'd0 || d_source[15:8] !== 8'h11 || d_size[3:2] !== 2'd1 || d_error[1] !== 1'b1) begin
        errors++; $display("FAIL stall_stable cyc=%0d got v=%b op=%0d src=%h sz=%0d exp v=1 op=0 src=11 sz=1", c, d_valid[1], d_opcode[5:3], d_source[15:8], d_size[3:2]);
      end
      checks++; if (d_valid[0] !== 1'b0 || d_valid[2] !== 1'b0) begin errors++; $display("FAIL stall_others got=%b exp=x0x zero", d_valid); end
      tick();
    end
    d_ready[1] = 1'b1;
    tick();
    d_ready[1] = 1'b0;
    checks++; if (d_valid[1] !== 1'b0) begin errors++; $display("FAIL stall_pop got=%b exp=0", d_valid[1]); end
  endtask

  task automatic test_full();
    drive(2, 3'd1, 8'd1, 2'd0); tick();
    drive(2, 3'd1, 8'd2, 2'd0); tick();
    drive(2, 3'd4, 8'd3, 2'd3);
    checks++; if (blk_ready[2] !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", blk_ready[2]); end
    tick();
    checks++; if (blk_ready[2] !== 1'b0 || d_source[23:16] !== 8'd1) begin errors++; $display("FAIL full_stall got rdy=%b src=%0d exp rdy=0 src=1", blk_ready[2], d_source[23:16]); end
    d_ready[2] = 1'b1;
    tick();
    d_ready[2] = 1'b0;
    checks++; if (blk_ready[2] !== 1'b1 || d_source[23:16] !== 8'd2) begin errors++; $display("FAIL full_afterpop got rdy=%b src=%0d exp rdy=1 src=2", blk_ready[2], d_source[23:16]); end
    tick();
    blk_valid[2] = 1'b0;
    d_ready[2] = 1'b1;
    checks++; if (d_source[23:16] !== 8'd2 || blk_ready[2] !== 1'b0) begin errors++; $display("FAIL full_order2 got src=%0d rdy=%b exp src=2 rdy=0", d_source[23:16], blk_ready[2]); end
    tick();
    checks++; if (d_source[23:16] !== 8'd3 || d_opcode[8:6] !== 3'd1 || d_size[5:4] !== 2'd3) begin errors++; $display("FAIL full_order3 got src=%0d op=%0d exp src=3 op=1", d_source[23:16], d_opcode[8:6]); end
    tick();
    d_ready[2] = 1'b0;
    checks++; if (d_valid[2] !== 1'b0) begin errors++; $display("FAIL full_drain got=%b exp=0", d_valid[2]); end
  endtask

  task automatic test_push_pop();
    drive(0, 3'd0, 8'h10, 2'd0); tick();
    drive(0, 3'd4, 8'h20, 2'd1);
    d_ready[0] = 1'b1;
    checks++; if (d_source[7:0] !== 8'h10) begin errors++; $display("FAIL pp_head got=%h exp=10", d_source[7:0]); end
    tick();
    blk_valid[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1 || d_valid[0] !== 1'b1 || d_source[7:0] !== 8'h20 || blk_ready[0] !== 1'b1) begin
      errors++; $display("FAIL pp_after got busy=%b v=%b src=%h rdy=%b exp 1 1 20 1", busy[0], d_valid[0], d_source[7:0], blk_ready[0]);
    end
    tick();
    d_ready[0] = 1'b0;
    checks++; if (d_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL pp_drain got v=%b busy=%b exp 0 0", d_valid[0], busy[0]); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < NM; m++) drive(m, 3'd4, 8'(8'h40 + 16*m + k), 2'd1);
      tick();
    end
    blk_valid = '0;
    checks++; if (blk_ready !== 3'b000 || d_valid !== 3'b111) begin errors++; $display("FAIL rm_full got rdy=%b v=%b exp 000 111", blk_ready, d_valid); end
    rst = 1'b1;
    #1;
    checks++; if (d_valid !== 3'b000 || busy !== 3'b000 || blk_ready !== 3'b111) begin errors++; $display("FAIL rm_immediate got v=%b busy=%b rdy=%b", d_valid, busy, blk_ready); end
    @(negedge clk);
    rst = 1'b0;
    d_ready = '1;
    tick();
    tick();
    checks++; if (d_valid !== 3'b000 || d_source !== '0) begin errors++; $display("FAIL rm_stale got v=%b src=%h exp 0", d_valid, d_source); end
    d_ready = '0;
  endtask

  task automatic test_random();
    logic [12:0] mq [NM][$];
    logic [12:0] hd;
    logic [2:0]  exp_op;
    bit          pu, po;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < NM; m++) begin
        blk_valid[m] = 1'($urandom_range(0, 1));
        blk_opcode[3*m +: 3] = 3'($urandom_range(0, 7));
        blk_source[AIW*m +: AIW] = 8'($urandom);
        blk_size[SZW*m +: SZW] = 2'($urandom_range(0, 3));
        d_ready[m] = ($urandom_range(0, 3) != 0);
      end
      for (int m = 0; m < NM; m++) begin
        checks++;
        if (blk_ready[m] !== (mq[m].size() != DEPTH) || d_valid[m] !== (mq[m].size() != 0) || busy[m] !== (mq[m].size() != 0)) begin
          errors++; $display("FAIL rnd_ctrl cyc=%0d m=%0d got rdy=%b v=%b busy=%b exp occupancy=%0d", c, m, blk_ready[m], d_valid[m], busy[m], mq[m].size());
        end
        if (mq[m].size() != 0) begin
          hd = mq[m][0];
          exp_op = (hd[12:10] == 3'd4) ? 3'd1 : 3'd0;
          checks++;
          if (d_opcode[3*m +: 3] !== exp_op || d_source[AIW*m +: AIW] !== hd[9:2] || d_size[SZW*m +: SZW] !== hd[1:0] || d_error[m] !== 1'b1 || d_data[DW*m +: DW] !== '0) begin
            errors++; $display("FAIL rnd_resp cyc=%0d m=%0d got op=%0d src=%h sz=%0d exp op=%0d src=%h sz=%0d", c, m, d_opcode[3*m +: 3], d_source[AIW*m +: AIW], d_size[SZW*m +: SZW], exp_op, hd[9:2], hd[1:0]);
          end
        end
      end
      for (int m = 0; m < NM; m++) begin
        pu = blk_valid[m] && (mq[m].size() < DEPTH);
        po = d_ready[m] && (mq[m].size() > 0);
        if (po) void'(mq[m].pop_front());
        if (pu) mq[m].push_back({blk_opcode[3*m +: 3], blk_source[AIW*m +: AIW], blk_size[SZW*m +: SZW]});
      end
      tick();
    end
    blk_valid = '0;
    d_ready = '1;
    tick(); tick(); tick();
    d_ready = '0;
    checks++; if (d_valid !== 3'b000) begin errors++; $display("FAIL rnd_drain got=%b exp=000", d_valid); end
  endtask

`ifdef IOPMP_ERR_CNT_EN
  task automatic test_counter();
    checks++; if (cnt !== '0) begin errors++; $display("FAIL cnt_reset got=%h exp=0", cnt); end
    drive(0, 3'd0, 8'h01, 2'd0);
    d_ready[0] = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    checks++; if (cnt[15:0] !== 16'hFFFE) begin errors++; $display("FAIL cnt_preload got=%h exp=fffe", cnt[15:0]); end
    tick(); tick(); tick();
    checks++; if (cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got=%h exp=ffff", cnt[15:0]); end
    cnt_clr[0] = 1'b1;
    tick();
    cnt_clr[0] = 1'b0;
    blk_valid[0] = 1'b0;
    checks++; if (cnt[15:0] !== 16'h0000) begin errors++; $display("FAIL cnt_clear got=%h exp=0", cnt[15:0]); end
    tick(); tick();
    d_ready[0] = 1'b0;
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_single_get();
    test_stall();
    test_full();
    test_push_pop();
    test_reset_mid();
    do_reset();
    test_random();
`ifdef IOPMP_ERR_CNT_EN
    do_reset();
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
